// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b - bIn, one full-subtractor bit
// per clock (LSB first) with a single borrow flip-flop and start/busy/done.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bOut,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic             bit_d, borrow_next, last_bit, accept;
  logic [WIDTH:0]   res_cat;
  logic [WIDTH-1:0] res_next;

  assign dbg_state = state;

  // Full-subtractor slice; the new bit enters the result register at the MSB.
  always_comb begin
    bit_d       = a_sr[0] ^ b_sr[0] ^ borrow;
    borrow_next = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & borrow) | (b_sr[0] & borrow);
    res_cat     = {bit_d, res_sr};
    res_next    = res_cat[WIDTH:1];
    last_bit    = (cnt == CW'(WIDTH - 1));
    accept      = start && (state != SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // diff/bOut only update on the final bit so they stay stable during SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bOut   <= 1'b0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      borrow <= bIn;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      borrow <= borrow_next;
      res_sr <= res_next;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        diff <= res_next;
        bOut <= borrow_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: three instances (WIDTH 1, 4, 8) share clock,
// reset and start; results are compared against plain integer subtraction.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] op_a, op_b;
  logic       op_bi;

  logic       busy1, done1, bout1;
  logic [0:0] diff1;
  logic [1:0] st1;
  logic       busy4, done4, bout4;
  logic [3:0] diff4;
  logic [1:0] st4;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;
  logic [1:0] st8;

  logic       busy_v [3];
  logic       done_v [3];
  logic       bout_v [3];
  logic [7:0] diff_v [3];
  int         wl [3] = '{1, 4, 8};

  logic [8:0] prev [3];
  logic [4:0] last4;
  logic [4:0] exp_q [$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(op_a[0:0]), .b(op_b[0:0]),
    .bIn(op_bi), .busy(busy1), .done(done1), .diff(diff1), .bOut(bout1),
    .dbg_state(st1)
  );
  serial_subtractor #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(op_a[3:0]), .b(op_b[3:0]),
    .bIn(op_bi), .busy(busy4), .done(done4), .diff(diff4), .bOut(bout4),
    .dbg_state(st4)
  );
  serial_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(op_a), .b(op_b),
    .bIn(op_bi), .busy(busy8), .done(done8), .diff(diff8), .bOut(bout8),
    .dbg_state(st8)
  );

  assign busy_v[0] = busy1;  assign done_v[0] = done1;
  assign bout_v[0] = bout1;  assign diff_v[0] = {7'd0, diff1};
  assign busy_v[1] = busy4;  assign done_v[1] = done4;
  assign bout_v[1] = bout4;  assign diff_v[1] = {4'd0, diff4};
  assign busy_v[2] = busy8;  assign done_v[2] = done8;
  assign bout_v[2] = bout8;  assign diff_v[2] = diff8;

  // Reference: {bOut, diff} from signed integer subtraction of w-bit operands.
  function automatic logic [8:0] model(input int w, input int a, input int b, input int bi);
    int m;
    int r;
    m = (1 << w) - 1;
    r = (a & m) - (b & m) - bi;
    model = {(r < 0) ? 1'b1 : 1'b0, 8'(r & m)};
  endfunction

  task automatic check(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) prev[i] = '0;
  endtask

  // One operation on all three widths; checks busy/done timing, held outputs
  // during SHIFT, the single done pulse and the result.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bi);
    logic [8:0] exp_r [3];
    int         done_j [3];
    logic [8:0] got [3];
    bit         ok [3];
    for (int i = 0; i < 3; i++) begin
      exp_r[i]  = model(wl[i], int'(a), int'(b), int'(bi));
      done_j[i] = -1;
      got[i]    = '0;
      ok[i]     = 1'b1;
    end
    @(negedge clk);
    op_a = a; op_b = b; op_bi = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_a = 8'($urandom); op_b = 8'($urandom); op_bi = 1'($urandom);
    for (int j = 0; j < 10; j++) begin
      for (int i = 0; i < 3; i++) begin
        if (busy_v[i] !== (j < wl[i])) ok[i] = 1'b0;
        if (done_v[i] === 1'b1) begin
          if (done_j[i] == -1) done_j[i] = j;
          else ok[i] = 1'b0;
          got[i] = {bout_v[i], diff_v[i]};
        end else if (done_v[i] !== 1'b0) ok[i] = 1'b0;
        if (j < wl[i]) begin
          if ({bout_v[i], diff_v[i]} !== prev[i]) ok[i] = 1'b0;
        end else if ({bout_v[i], diff_v[i]} !== exp_r[i]) ok[i] = 1'b0;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      check(ok[i] && done_j[i] == wl[i], $sformatf("op_w%0d", wl[i]),
            $sformatf("a=%h b=%h bIn=%b got done_at=%0d bOut/diff=%h expected done_at=%0d bOut/diff=%h",
                      a, b, bi, done_j[i], got[i], wl[i], exp_r[i]));
      prev[i] = exp_r[i];
    end
    last4 = {got[1][8], got[1][3:0]};
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bi;
    logic [3:0] d;
    logic       bo;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         dcount;
    bit         flag;
    logic [8:0] m;
    logic [7:0] ra, rb;
    logic       rbi;
    logic [4:0] e;

    tbl[0] = '{4'h9, 4'h3, 1'b0, 4'h6, 1'b0};
    tbl[1] = '{4'h3, 4'h9, 1'b0, 4'hA, 1'b1};
    tbl[2] = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1};
    tbl[3] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b0};
    tbl[4] = '{4'hF, 4'h0, 1'b1, 4'hE, 1'b0};
    tbl[5] = '{4'h0, 4'hF, 1'b0, 4'h1, 1'b1};
    tbl[6] = '{4'h7, 4'h7, 1'b1, 4'hF, 1'b1};

    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; op_bi = 1'b0;
    for (int i = 0; i < 3; i++) prev[i] = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++)
      check(busy_v[i] === 1'b0 && done_v[i] === 1'b0 && diff_v[i] === 8'd0 && bout_v[i] === 1'b0,
            $sformatf("reset_w%0d", wl[i]),
            $sformatf("got busy=%b done=%b diff=%h bOut=%b expected all 0",
                      busy_v[i], done_v[i], diff_v[i], bout_v[i]));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int t = 0; t < 7; t++) begin
      run_op({4'd0, tbl[t].a}, {4'd0, tbl[t].b}, tbl[t].bi);
      check(last4 === {tbl[t].bo, tbl[t].d}, $sformatf("table_%0d", t),
            $sformatf("got bOut/diff=%h expected %h", last4, {tbl[t].bo, tbl[t].d}));
    end

    // start pulsed again while busy must be ignored
    reset_dut();
    @(negedge clk);
    op_a = 8'h09; op_b = 8'h03; op_bi = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcount = 0;
    for (int j = 0; j < 8; j++) begin
      if (done4 === 1'b1) begin
        dcount++;
        check(j == 4 && diff4 === 4'h6 && bout4 === 1'b0, "ignored_start_result",
              $sformatf("got at=%0d diff=%h bOut=%b expected at=4 diff=6 bOut=0", j, diff4, bout4));
      end
      if (j == 1) begin op_a = 8'h0F; op_b = 8'h00; start = 1'b1; end
      if (j == 2) start = 1'b0;
      @(negedge clk);
    end
    check(dcount == 1, "ignored_start_pulses", $sformatf("got %0d done pulses expected 1", dcount));

    // start held high: back-to-back ops every WIDTH+1 cycles
    reset_dut();
    exp_q.delete();
    @(negedge clk);
    ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
    op_a = ra; op_b = rb; op_bi = rbi; start = 1'b1;
    m = model(4, int'(ra), int'(rb), int'(rbi));
    exp_q.push_back({m[8], m[3:0]});
    @(negedge clk);
    dcount = 0;
    for (int j = 0; j < 15; j++) begin
      if (done4 === 1'b1) begin
        dcount++;
        if (exp_q.size() == 0)
          check(1'b0, "held_start_extra", $sformatf("unexpected done at %0d diff=%h", j, diff4));
        else begin
          e = exp_q.pop_front();
          check(j % 5 == 4 && {bout4, diff4} === e, "held_start_result",
                $sformatf("got at=%0d bOut/diff=%h expected at=%0d bOut/diff=%h",
                          j, {bout4, diff4}, (dcount * 5) - 1, e));
        end
      end
      if (j == 0 || j == 5) begin
        ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
        op_a = ra; op_b = rb; op_bi = rbi;
        m = model(4, int'(ra), int'(rb), int'(rbi));
        exp_q.push_back({m[8], m[3:0]});
      end
      if (j == 14) start = 1'b0;
      @(negedge clk);
    end
    check(dcount == 3 && exp_q.size() == 0, "held_start_count",
          $sformatf("got %0d done pulses, %0d pending, expected 3 and 0", dcount, exp_q.size()));

    // asynchronous reset in the middle of SHIFT
    reset_dut();
    run_op(8'h09, 8'h03, 1'b0);
    @(negedge clk);
    op_a = 8'h05; op_b = 8'h02; op_bi = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check(busy4 === 1'b0 && done4 === 1'b0 && diff4 === 4'h0 && bout4 === 1'b0, "abort_outputs",
          $sformatf("got busy=%b done=%b diff=%h bOut=%b expected all 0", busy4, done4, diff4, bout4));
    flag = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done4 !== 1'b0 || busy4 !== 1'b0) flag = 1'b1;
    end
    check(!flag, "abort_no_done", "busy or done seen while reset held");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) prev[i] = '0;
    run_op(8'h0C, 8'h05, 1'b1);
    check(last4 === 5'h06, "after_abort",
          $sformatf("got bOut/diff=%h expected 06", last4));

    // Exhaustive 4-bit (also sweeps WIDTH=1 fully), random upper bits for WIDTH=8
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int bi = 0; bi < 2; bi++)
          run_op({4'($urandom), 4'(a)}, {4'($urandom), 4'(b)}, 1'(bi));

    // Random full-width operands
    for (int n = 0; n < 200; n++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
